fpmul_rr_sched: RTL

Round-robin scheduler that shares one pipelined FPmul (single-precision, fixed latency, no stall input) among NREQ requesters. Each requester has a valid/ready request port and a valid/ready response port. The scheduler registers the operands into the multiplier and tags each issue with the requester ID. It steers each result back to the owning requester's response register. It sits between the per-lane test/compute agents and the shared FPmul instance, which is instantiated beside it at the same hierarchy level.

---
 rtl/fpmul_rr_sched_pkg.sv | 15 +
 rtl/fpmul_rr_sched_if.sv | 34 +++
 rtl/fpmul_rr_sched_arb.sv | 31 +++
 rtl/fpmul_rr_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fpmul_rr_sched_pkg.sv
// Shared types for the round-robin FPmul scheduler.
// The tag struct depends on NREQ, so the scheduler declares it locally from
// the idx_w() width helper below.
package fpmul_sched_pkg;

   localparam int FP_W = 32;

   typedef logic [FP_W-1:0] fp32_t;

   // Width of a requester index for n requesters (never less than one bit).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpmul_rr_sched_if.sv
// Bundle of requester-side handshakes and the FPmul operand/result bus.
// slave: the scheduler. master: requester agents plus the shared FPmul.
interface fpmul_rr_sched_if
   import fpmul_sched_pkg::*;
#(
   parameter int NREQ = 4
) ();

   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   fp32_t [NREQ-1:0] req_a;
   fp32_t [NREQ-1:0] req_b;

   logic [NREQ-1:0]  rsp_valid;
   logic [NREQ-1:0]  rsp_ready;
   fp32_t [NREQ-1:0] rsp_data;

   fp32_t            mul_a;
   fp32_t            mul_b;
   fp32_t            mul_z;

   logic             busy;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_z,
      output req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_z,
      input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy
   );

endinterface

// File: rtl/fpmul_rr_sched_arb.sv
// Combinational round-robin pick: first eligible index at or after ptr,
// wrapping modulo NREQ. The pointer itself is owned by the caller.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   // Walk NREQ offsets from ptr; the first eligible hit wins and locks out the rest.
   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && eligible[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/fpmul_rr_sched.sv
// Shares one fixed-latency pipelined FPmul among NREQ requesters.
// Operands are registered toward the multiplier, each issue carries its
// requester ID down a tag pipe, and the product lands in that requester's
// response register. Data passes through bit-exact.
module fpmul_rr_sched
   import fpmul_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int LATENCY = 4
) (
   input  logic           clk,
   input  logic           rst,
   fpmul_rr_sched_if.slave bus
);

   localparam int IDW = idx_w(NREQ);

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [NREQ-1:0]  pending_reg;
   logic [NREQ-1:0]  rsp_valid_reg;
   fp32_t [NREQ-1:0] rsp_data_reg;
   fp32_t            mul_a_reg;
   fp32_t            mul_b_reg;
   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   ptr_next;

   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             accept;
   logic [NREQ-1:0]  cap_hit;
   logic [NREQ-1:0]  rsp_hs;

   // Stage 0 is written at the accept edge and tracks the cycle in which the
   // operands sit on mul_a/mul_b; stage LATENCY therefore lines up with the
   // cycle in which mul_z carries their product.
   tag_t tag_pipe [LATENCY+1];

   assign eligible = bus.req_valid & ~pending_reg;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .eligible  (eligible),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign accept   = |grant;
   assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
   assign rsp_hs   = rsp_valid_reg & bus.rsp_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cap
         assign cap_hit[gi] = tag_pipe[LATENCY].vld && (tag_pipe[LATENCY].id == IDW'(gi));
      end
   endgenerate

   // Latch the granted operands for the multiplier and advance the rotation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a_reg <= '0;
         mul_b_reg <= '0;
         ptr_reg   <= '0;
      end else if (accept) begin
         mul_a_reg <= bus.req_a[grant_idx];
         mul_b_reg <= bus.req_b[grant_idx];
         ptr_reg   <= ptr_next;
      end
   end

   // Shift the ownership tags alongside the multiplier pipeline; reset drops them all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= LATENCY; k++) begin
            tag_pipe[k] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{vld: accept, id: grant_idx};
         for (int k = 1; k <= LATENCY; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
      end
   end

   // Per-lane bookkeeping: pending spans accept..response handshake, so a
   // capture and a handshake for the same lane can never coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_reg   <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (cap_hit[i]) begin
               rsp_valid_reg[i] <= 1'b1;
               rsp_data_reg[i]  <= bus.mul_z;
            end else if (rsp_hs[i]) begin
               rsp_valid_reg[i] <= 1'b0;
            end
            if (grant[i]) begin
               pending_reg[i] <= 1'b1;
            end else if (rsp_hs[i]) begin
               pending_reg[i] <= 1'b0;
            end
         end
      end
   end

   // Grants are suppressed combinationally while reset is held.
   assign bus.req_ready = rst ? '0 : grant;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.mul_a     = mul_a_reg;
   assign bus.mul_b     = mul_b_reg;
   assign bus.busy      = |pending_reg;

endmodule
